// File: rtl/counters_pkg.sv
// Shared constants and helpers for the counter bank and its channels.
// Mode encodings, default counter width and flattened-vector slicing.
package counters_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam int CNT_W    = 32;
    localparam int MAX_CH   = 32;
    localparam int FLAT_MAX = MAX_CH * CNT_W;

    // Callers zero-extend the flattened bus to FLAT_MAX and keep the low WIDTH bits.
    function automatic logic [CNT_W-1:0] chan_slice(input logic [FLAT_MAX-1:0] vec,
                                                    input int unsigned idx,
                                                    input int unsigned w);
        logic [FLAT_MAX-1:0] shifted;
        shifted = vec >> (idx * w);
        return shifted[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/counter_chan.sv
// One down-counter channel: load, one-shot/auto-reload count, sticky flag,
// expiry pulse and the optional two-strike watchdog behaviour.
module counter_chan
    import counters_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter bit IS_WD = 1'b0
) (
    input  logic             sysclk,
    input  logic             foo_card,
    input  logic             load,
    input  logic             ce,
    input  logic             mode,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] turn,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             cwm,
    output logic             pull,
    output logic             wd_pulse
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_r, count_nx_s;
    logic             busy_r, busy_nx_s;
    logic             cwm_r, cwm_nx_s, cwm_set_s;
    logic             pull_r, pull_nx_s;
    logic             strike_r, strike_nx_s;
    logic             wd_r, wd_nx_s;
    logic             reload_s;

    // Next-state decode: load beats count, count beats idle; the flag clear wins over a set.
    always_comb begin
        count_nx_s  = count_r;
        busy_nx_s   = busy_r;
        strike_nx_s = strike_r;
        cwm_set_s   = 1'b0;
        pull_nx_s   = 1'b0;
        wd_nx_s     = 1'b0;
        reload_s    = IS_WD ? MODE_RELOAD : mode;
        if (load) begin
            count_nx_s  = turn;
            busy_nx_s   = (turn != ZERO_C);
            strike_nx_s = 1'b0;
        end else if (busy_r && ce) begin
            if (reload_s == MODE_ONESHOT) begin
                if (!cwm_r) begin
                    count_nx_s = count_r - ONE_C;
                    if (count_r == ONE_C) begin
                        busy_nx_s = 1'b0;
                        cwm_set_s = 1'b1;
                        pull_nx_s = 1'b1;
                    end else begin
                        busy_nx_s = busy_r;
                    end
                end else begin
                    count_nx_s = count_r;
                end
            end else if (count_r != ZERO_C) begin
                count_nx_s = count_r - ONE_C;
            end else if (IS_WD && strike_r) begin
                // Second strike: fire the watchdog pulse and park until reloaded.
                count_nx_s = turn;
                busy_nx_s  = 1'b0;
                wd_nx_s    = 1'b1;
            end else begin
                count_nx_s  = turn;
                cwm_set_s   = 1'b1;
                pull_nx_s   = 1'b1;
                strike_nx_s = IS_WD ? 1'b1 : strike_r;
            end
        end else begin
            count_nx_s = count_r;
        end
        cwm_nx_s = clr_n ? (cwm_r | cwm_set_s) : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (foo_card) begin
            count_r  <= ZERO_C;
            busy_r   <= 1'b0;
            cwm_r    <= 1'b0;
            pull_r   <= 1'b0;
            strike_r <= 1'b0;
            wd_r     <= 1'b0;
        end else begin
            count_r  <= count_nx_s;
            busy_r   <= busy_nx_s;
            cwm_r    <= cwm_nx_s;
            pull_r   <= pull_nx_s;
            strike_r <= strike_nx_s;
            wd_r     <= wd_nx_s;
        end
    end

    assign count    = count_r;
    assign busy     = busy_r;
    assign cwm      = cwm_r;
    assign pull     = pull_r;
    assign wd_pulse = wd_r;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH down-counter channels with optional cascading, one watchdog
// channel, an aggregated interrupt and the watchdog second-strike pulse.
module counter_bank
    import counters_pkg::*;
#(
    parameter int             NCH     = 6,
    parameter int             WIDTH   = CNT_W,
    parameter logic [NCH-1:0] CASCADE = {NCH{1'b0}},
    parameter int             WD_CH   = 0
) (
    input  logic                 sysclk,
    input  logic                 foo_card,
    input  logic [NCH-1:0]       baz,
    input  logic [NCH-1:0]       blrb,
    input  logic [NCH-1:0]       bar,
    input  logic [NCH-1:0]       zz1pb,
    input  logic [NCH*WIDTH-1:0] turn,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       cwm,
    output logic [NCH-1:0]       pull,
    output logic                 irq,
    output logic                 wdfilecard
);

    logic [FLAT_MAX-1:0] turn_ext_s;
    logic [NCH-1:0]      pull_s;
    logic [NCH-1:0]      wd_s;

    assign turn_ext_s = FLAT_MAX'(turn);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        localparam int PREV = (i > 0) ? i - 1 : 0;
        localparam bit CASC = (i > 0) && CASCADE[i];

        logic             ce_s;
        logic [CNT_W-1:0] turn_sl_s;

        // A cascaded stage counts on the previous channel's registered expiry pulse.
        assign ce_s      = CASC ? pull_s[PREV] : blrb[i];
        assign turn_sl_s = chan_slice(turn_ext_s, i, WIDTH);

        counter_chan #(
            .WIDTH (WIDTH),
            .IS_WD (i == WD_CH)
        ) u_chan (
            .sysclk   (sysclk),
            .foo_card (foo_card),
            .load     (baz[i]),
            .ce       (ce_s),
            .mode     (bar[i]),
            .clr_n    (zz1pb[i]),
            .turn     (turn_sl_s[WIDTH-1:0]),
            .count    (count[i*WIDTH +: WIDTH]),
            .busy     (busy[i]),
            .cwm      (cwm[i]),
            .pull     (pull_s[i]),
            .wd_pulse (wd_s[i])
        );
    end

    assign pull       = pull_s;
    assign irq        = |cwm;
    assign wdfilecard = |wd_s;

endmodule
